// File: rtl/dm_result_dumper_if.sv
// Result stream port of the end-of-test dumper: valid/ready handshake plus
// word data, stream index and last-word marker.
interface dm_result_dumper_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W:0]   idx;
  logic              last;

  modport master (output valid, output data, output idx, output last, input ready);
  modport slave  (input valid, input data, input idx, input last, output ready);
endinterface

// File: rtl/dm_result_dumper.sv
// End-of-test result reader. Watches the core's DM write port for the
// end-of-simulation store, then stalls the core, reads the result window
// out of DM and streams it, optionally followed by the frozen cycle count.
//
// state  | meaning
// IDLE   | core running, cycle counter live, snooping for the end store
// READ   | DM read strobe for result word idx
// WAIT   | DM data returns, captured into the output register
// SEND   | result word offered, waiting for out_ready
// CYC_LO | cycle count low word offered
// CYC_HI | cycle count high word offered (always the last word)
// DONE   | dump finished, terminal until reset
module dm_result_dumper #(
  parameter int                 ADDR_W     = 14,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 14'h3FFF,
  parameter logic [DATA_W-1:0]  END_CODE   = 32'hFFFF_FFFF,
  parameter logic [ADDR_W-1:0]  START_ADDR = 14'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_num,
  input  logic              cfg_rdcycle,
  input  logic              snoop_ceb,
  input  logic              snoop_web,
  input  logic [DATA_W-1:0] snoop_bweb,
  input  logic [ADDR_W-1:0] snoop_a,
  input  logic [DATA_W-1:0] snoop_d,
  output logic              core_hold,
  output logic              dm_ceb,
  output logic [ADDR_W-1:0] dm_a,
  input  logic [DATA_W-1:0] dm_q,
  dm_result_dumper_if.master out_if,
  output logic              done,
  output logic [63:0]       cycle_cnt
);

  localparam int IW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, SEND, CYC_LO, CYC_HI, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic              rdc_q, rdc_d;
  logic [63:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     oidx_q, oidx_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic          trig;
  logic          idx_last;
  logic [IW-1:0] num_ext;

  assign trig = (state_q == IDLE) && !snoop_ceb && !snoop_web &&
                (snoop_bweb == '0) && (snoop_a == END_ADDR) && (snoop_d == END_CODE);
  assign num_ext  = {1'b0, num_q};
  assign idx_last = (idx_q == num_ext - IW'(1));

  // Next-state, datapath and stream register updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    rdc_d   = rdc_q;
    cnt_d   = (state_q == IDLE) ? cnt_q + 64'd1 : cnt_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          num_d = cfg_num;
          rdc_d = cfg_rdcycle;
          idx_d = '0;
          if (cfg_num != '0) begin
            state_d = READ;
          end else if (cfg_rdcycle) begin
            // cnt_d already includes the trigger edge
            state_d = CYC_LO;
            data_d  = DATA_W'(cnt_d[31:0]);
            oidx_d  = {1'b0, cfg_num};
            valid_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        data_d  = dm_q;
        oidx_d  = idx_q;
        last_d  = idx_last && !rdc_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && out_if.ready) begin
          idx_d = idx_q + IW'(1);
          if (idx_last && rdc_q) begin
            state_d = CYC_LO;
            data_d  = DATA_W'(cnt_q[31:0]);
            oidx_d  = num_ext;
            last_d  = 1'b0;
          end else if (idx_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d = READ;
            valid_d = 1'b0;
          end
        end
      end
      CYC_LO: begin
        if (out_if.ready) begin
          state_d = CYC_HI;
          data_d  = DATA_W'(cnt_q[63:32]);
          oidx_d  = num_ext + IW'(1);
          last_d  = 1'b1;
        end
      end
      CYC_HI: begin
        if (out_if.ready) begin
          state_d = DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      rdc_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      rdc_q   <= rdc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign core_hold    = (state_q != IDLE);
  assign dm_ceb       = (state_q != READ);
  assign dm_a         = (state_q == READ) ? START_ADDR + idx_q[ADDR_W-1:0] : '0;
  assign done         = (state_q == DONE);
  assign cycle_cnt    = cnt_q;
  assign out_if.valid = valid_q;
  assign out_if.data  = data_q;
  assign out_if.idx   = oidx_q;
  assign out_if.last  = last_q;

endmodule

// File: tb/tb_dm_result_dumper.sv
// Bench for dm_result_dumper: DM model, scoreboard of expected stream words,
// handshake monitor on the falling edge.
module tb_dm_result_dumper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] cfg_num = 14'd3;
  logic        cfg_rdcycle = 1'b0;
  logic        snoop_ceb = 1'b1;
  logic        snoop_web = 1'b1;
  logic [31:0] snoop_bweb = '1;
  logic [13:0] snoop_a = '0;
  logic [31:0] snoop_d = '0;
  logic        core_hold;
  logic        dm_ceb;
  logic [13:0] dm_a;
  logic [31:0] dm_q = '0;
  logic        done;
  logic [63:0] cycle_cnt;

  always #5 clk = ~clk;

  dm_result_dumper_if #(.ADDR_W(14), .DATA_W(32)) sif ();

  dm_result_dumper dut (
    .clk(clk), .rst(rst),
    .cfg_num(cfg_num), .cfg_rdcycle(cfg_rdcycle),
    .snoop_ceb(snoop_ceb), .snoop_web(snoop_web), .snoop_bweb(snoop_bweb),
    .snoop_a(snoop_a), .snoop_d(snoop_d),
    .core_hold(core_hold), .dm_ceb(dm_ceb), .dm_a(dm_a), .dm_q(dm_q),
    .out_if(sif), .done(done), .cycle_cnt(cycle_cnt)
  );

  logic [31:0] mem [0:15];

  // DM model: one-cycle read latency
  always @(posedge clk) if (!dm_ceb) dm_q <= mem[dm_a[3:0]];

  typedef struct packed {
    logic [31:0] d;
    logic [14:0] i;
    logic        l;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          rd_cnt = 0;
  int          v_cnt = 0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic [14:0] prev_i = '0;

  // Stream monitor: scoreboard pop on handshake, stability under backpressure
  always @(negedge clk) begin
    if (rst) begin
      if (!dm_ceb) rd_cnt <= rd_cnt + 1;
      if (sif.valid) v_cnt <= v_cnt + 1;
      if (sif.valid && !sif.ready) stall_cnt <= stall_cnt + 1;
      if (prev_stall) begin
        chk("hold_valid", sif.valid, 1);
        chk("hold_data", sif.data, prev_d);
        chk("hold_idx", sif.idx, prev_i);
      end
      prev_stall <= sif.valid && !sif.ready;
      prev_d     <= sif.data;
      prev_i     <= sif.idx;
      if (sif.valid && sif.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", sif.data, 64'hDEAD_0000_0000);
        end else begin
          chk("word_data", sif.data, sb[0].d);
          chk("word_idx", sif.idx, sb[0].i);
          chk("word_last", sif.last, sb[0].l);
          void'(sb.pop_front());
        end
      end
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_hold", core_hold, 0);
    chk("rst_ceb", dm_ceb, 1);
    chk("rst_a", dm_a, 0);
    chk("rst_valid", sif.valid, 0);
    chk("rst_data", sif.data, 0);
    chk("rst_idx", sif.idx, 0);
    chk("rst_last", sif.last, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cycle_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    snoop_ceb = 1'b1; snoop_web = 1'b1; snoop_bweb = '1;
    snoop_a = '0; snoop_d = '0;
    sif.ready = 1'b1;
    sb.delete();
    #1;
    chk_reset_vals();
    tick(2);
    rst = 1'b1;
  endtask

  // One-cycle core store; returns at posedge+1 of the store edge
  task automatic store(input logic [13:0] a, input logic [31:0] d, input logic [31:0] bweb);
    snoop_ceb = 1'b0; snoop_web = 1'b0; snoop_bweb = bweb;
    snoop_a = a; snoop_d = d;
    tick(1);
    snoop_ceb = 1'b1; snoop_web = 1'b1; snoop_bweb = '1;
  endtask

  task automatic push_dump(input int num, input bit rdc, input logic [63:0] cnt);
    for (int i = 0; i < num; i++)
      sb.push_back('{d: mem[i], i: 15'(i), l: (i == num - 1) && !rdc});
    if (rdc) begin
      sb.push_back('{d: cnt[31:0], i: 15'(num), l: 1'b0});
      sb.push_back('{d: cnt[63:32], i: 15'(num + 1), l: 1'b1});
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_idx1(input string tag);
    int n = 0;
    while (!(sif.valid && sif.idx == 15'd1) && n < 50) begin
      tick(1);
      n++;
    end
    chk({tag, "_reach_idx1"}, sif.valid && sif.idx == 15'd1, 1);
  endtask

  int rd0, v0, s0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33;
    sif.ready = 1'b1;
    #2;

    // T2 then T1 from the same reset
    do_reset();
    v0 = v_cnt;
    store(14'h3FFE, 32'hFFFF_FFFF, 32'h0);
    chk("t2_addr_hold", core_hold, 0);
    store(14'h3FFF, 32'hFFFF_FFFE, 32'h0);
    chk("t2_data_hold", core_hold, 0);
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0000_FFFF);
    chk("t2_mask_hold", core_hold, 0);
    tick(4);
    chk("t2_hold_late", core_hold, 0);
    chk("t2_no_valid", v_cnt - v0, 0);

    cfg_num = 14'd3; cfg_rdcycle = 1'b0;
    push_dump(3, 0, 64'd0);
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0);
    chk("t1_hold_next", core_hold, 1);
    wait_done("t1", 100);
    tick(3);
    chk("t1_done_sticky", done, 1);
    chk("t1_hold_sticky", core_hold, 1);
    chk("t1_valid_off", sif.valid, 0);

    // T3 backpressure at idx 1
    do_reset();
    rd0 = rd_cnt; s0 = stall_cnt;
    push_dump(3, 0, 64'd0);
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0);
    wait_idx1("t3");
    sif.ready = 1'b0;
    tick(5);
    chk("t3_data_stalled", sif.data, 32'd22);
    sif.ready = 1'b1;
    wait_done("t3", 100);
    chk("t3_reads", rd_cnt - rd0, 3);
    chk("t3_stall_cycles", stall_cnt - s0, 5);

    // T4 cycle-count append, trigger on the 100th edge
    do_reset();
    cfg_num = 14'd1; cfg_rdcycle = 1'b1;
    push_dump(1, 1, 64'd100);
    tick(99);
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0);
    chk("t4_cnt_frozen", cycle_cnt, 64'd100);
    wait_done("t4", 100);
    tick(5);
    chk("t4_cnt_still", cycle_cnt, 64'd100);

    // T5 empty dump
    do_reset();
    rd0 = rd_cnt; v0 = v_cnt;
    cfg_num = 14'd0; cfg_rdcycle = 1'b0;
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0);
    chk("t5_done_next", done, 1);
    tick(5);
    chk("t5_no_reads", rd_cnt - rd0, 0);
    chk("t5_no_valid", v_cnt - v0, 0);
    chk("t5_done_sticky", done, 1);

    // T6 reset mid-SEND, then full rerun
    do_reset();
    cfg_num = 14'd3; cfg_rdcycle = 1'b0;
    push_dump(3, 0, 64'd0);
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0);
    wait_idx1("t6");
    sif.ready = 1'b0;
    tick(2);
    rst = 1'b0;
    #1;
    chk_reset_vals();
    sb.delete();
    tick(2);
    rst = 1'b1;
    sif.ready = 1'b1;
    tick(3);
    push_dump(3, 0, 64'd0);
    store(14'h3FFF, 32'hFFFF_FFFF, 32'h0);
    chk("t6_hold_next", core_hold, 1);
    wait_done("t6", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
